// File: rtl/isp_pkg.sv
// Shared types and helpers for the raw Bayer pipeline stages.
// Holds pattern/channel enums, the gain fraction width and the channel-select function.
package isp_pkg;

    typedef enum logic [1:0] {
        PAT_RGGB = 2'd0,
        PAT_GRBG = 2'd1,
        PAT_GBRG = 2'd2,
        PAT_BGGR = 2'd3
    } bayer_pattern_e;

    typedef enum logic [1:0] {
        CH_R  = 2'd0,
        CH_GR = 2'd1,
        CH_GB = 2'd2,
        CH_B  = 2'd3
    } bayer_chan_e;

    localparam int GAIN_FW = 8;

    // Every pattern is RGGB with columns and/or rows swapped, which flips the
    // matching bit of the 2x2 position index.
    function automatic bayer_chan_e chan_sel(input bayer_pattern_e pat,
                                             input logic row_odd,
                                             input logic col_odd);
        logic [1:0] pos;
        pos = {row_odd, col_odd} ^ 2'(pat);
        return bayer_chan_e'(pos);
    endfunction

endpackage

// File: rtl/isp_raster_cnt.sv
// Raster position counter: advances on each accepted beat and flags the
// first and last pixel of a frame on the beat that carries them.
module isp_raster_cnt #(
    parameter int H  = 1280,
    parameter int V  = 720,
    parameter int HW = 11,
    parameter int VW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vld,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          frame_start,
    output logic          frame_last
);

    logic [HW-1:0] h_cnt_r;
    logic [VW-1:0] v_cnt_r;
    logic          h_wrap_s;
    logic          v_wrap_s;

    assign h_wrap_s = (h_cnt_r == HW'(H - 1));
    assign v_wrap_s = (v_cnt_r == VW'(V - 1));

    // Horizontal/vertical position of the next accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_r <= '0;
            v_cnt_r <= '0;
        end else if (vld) begin
            if (h_wrap_s) begin
                h_cnt_r <= '0;
                v_cnt_r <= v_wrap_s ? '0 : v_cnt_r + VW'(1);
            end else begin
                h_cnt_r <= h_cnt_r + HW'(1);
            end
        end
    end

    assign h_cnt       = h_cnt_r;
    assign v_cnt       = v_cnt_r;
    assign frame_start = vld && (h_cnt_r == '0) && (v_cnt_r == '0);
    assign frame_last  = vld && h_wrap_s && v_wrap_s;

endmodule

// File: rtl/blc.sv
// Black-level correction: per-Bayer-channel offset subtract, then common
// normalisation gain with rounding and saturation; 2-cycle fixed latency.
module blc
    import isp_pkg::*;
#(
    parameter int DW = 16,
    parameter int H  = 1280,
    parameter int V  = 720,
    parameter int HW = 11,
    parameter int VW = 10,
    parameter int GW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          blc_en,
    input  logic          cfg_update,
    input  logic [1:0]    bayer_pattern,
    input  logic [DW-1:0] blc_r,
    input  logic [DW-1:0] blc_gr,
    input  logic [DW-1:0] blc_gb,
    input  logic [DW-1:0] blc_b,
    input  logic [GW-1:0] norm_gain,
    input  logic [DW-1:0] pixel_data_in,
    input  logic          pixel_data_in_vld,
    output logic [DW-1:0] pixel_data_out,
    output logic          pixel_data_out_vld,
    output logic          blc_done
);

    localparam int PW = DW + GW + 1;
    localparam int SW = PW - GAIN_FW;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          frame_start;
    logic          frame_last;

    isp_raster_cnt #(.H(H), .V(V), .HW(HW), .VW(VW)) u_raster_cnt (
        .clk         (clk),
        .rst         (rst),
        .vld         (pixel_data_in_vld),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .frame_start (frame_start),
        .frame_last  (frame_last)
    );

    logic [DW-1:0]  act_off_r_r, act_off_gr_r, act_off_gb_r, act_off_b_r;
    logic [GW-1:0]  act_gain_r;
    bayer_pattern_e act_pat_r;
    logic           act_en_r;
    logic           cfg_pending_r;
    logic           load_s;

    assign load_s = frame_start && (cfg_pending_r || cfg_update);

    // Shadow configuration: loaded only on a frame-start beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_off_r_r   <= '0;
            act_off_gr_r  <= '0;
            act_off_gb_r  <= '0;
            act_off_b_r   <= '0;
            act_gain_r    <= GW'(256);
            act_pat_r     <= PAT_RGGB;
            act_en_r      <= 1'b0;
            cfg_pending_r <= 1'b1;
        end else if (load_s) begin
            act_off_r_r   <= blc_r;
            act_off_gr_r  <= blc_gr;
            act_off_gb_r  <= blc_gb;
            act_off_b_r   <= blc_b;
            act_gain_r    <= norm_gain;
            act_pat_r     <= bayer_pattern_e'(bayer_pattern);
            act_en_r      <= blc_en;
            cfg_pending_r <= 1'b0;
        end else if (cfg_update) begin
            cfg_pending_r <= 1'b1;
        end
    end

    logic [DW-1:0]  eff_off_r_s, eff_off_gr_s, eff_off_gb_s, eff_off_b_s;
    logic [GW-1:0]  eff_gain_s;
    bayer_pattern_e eff_pat_s;
    logic           eff_en_s;
    logic [DW-1:0]  off_s;
    logic [DW:0]    sub_s;
    logic [DW-1:0]  diff_s;

    // Bypass mux so the frame-start pixel already sees the freshly loaded config,
    // followed by channel offset select and clamped subtraction.
    always_comb begin
        eff_off_r_s  = act_off_r_r;
        eff_off_gr_s = act_off_gr_r;
        eff_off_gb_s = act_off_gb_r;
        eff_off_b_s  = act_off_b_r;
        eff_gain_s   = act_gain_r;
        eff_pat_s    = act_pat_r;
        eff_en_s     = act_en_r;
        if (load_s) begin
            eff_off_r_s  = blc_r;
            eff_off_gr_s = blc_gr;
            eff_off_gb_s = blc_gb;
            eff_off_b_s  = blc_b;
            eff_gain_s   = norm_gain;
            eff_pat_s    = bayer_pattern_e'(bayer_pattern);
            eff_en_s     = blc_en;
        end else begin
            eff_en_s     = act_en_r;
        end

        case (chan_sel(eff_pat_s, v_cnt[0], h_cnt[0]))
            CH_R:    off_s = eff_off_r_s;
            CH_GR:   off_s = eff_off_gr_s;
            CH_GB:   off_s = eff_off_gb_s;
            CH_B:    off_s = eff_off_b_s;
            default: off_s = '0;
        endcase

        sub_s = {1'b0, pixel_data_in} - {1'b0, off_s};
        if (!eff_en_s) begin
            diff_s = pixel_data_in;
        end else if (sub_s[DW]) begin
            diff_s = '0;
        end else begin
            diff_s = sub_s[DW-1:0];
        end
    end

    logic          s1_vld_r;
    logic          s1_last_r;
    logic          s1_en_r;
    logic [DW-1:0] s1_diff_r;
    logic [GW-1:0] s1_gain_r;

    // Stage 1: offset-corrected sample plus the gain/enable it must be scaled with.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_r  <= 1'b0;
            s1_last_r <= 1'b0;
            s1_en_r   <= 1'b0;
            s1_diff_r <= '0;
            s1_gain_r <= '0;
        end else begin
            s1_vld_r  <= pixel_data_in_vld;
            s1_last_r <= frame_last;
            if (pixel_data_in_vld) begin
                s1_en_r   <= eff_en_s;
                s1_diff_r <= diff_s;
                s1_gain_r <= eff_gain_s;
            end
        end
    end

    logic [PW-1:0] rnd_s;
    logic [SW-1:0] shr_s;
    logic [DW-1:0] scaled_s;

    // Gain multiply, round half up at the fixed-point boundary, then saturate.
    always_comb begin
        rnd_s = PW'(s1_diff_r * s1_gain_r) + PW'(1 << (GAIN_FW - 1));
        shr_s = rnd_s[PW-1:GAIN_FW];
        if (|shr_s[SW-1:DW]) begin
            scaled_s = '1;
        end else begin
            scaled_s = shr_s[DW-1:0];
        end
    end

    logic [DW-1:0] out_r;
    logic          out_vld_r;
    logic          done_r;

    // Stage 2: registered outputs; data holds while no valid beat is present.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r     <= '0;
            out_vld_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            out_vld_r <= s1_vld_r;
            done_r    <= s1_vld_r && s1_last_r;
            if (s1_vld_r) begin
                out_r <= s1_en_r ? scaled_s : s1_diff_r;
            end
        end
    end

    assign pixel_data_out     = out_r;
    assign pixel_data_out_vld = out_vld_r;
    assign blc_done           = done_r;

endmodule

// File: tb/tb_blc.sv
// Self-checking bench for blc on a small 8x4 raster: directed test-plan cases
// plus randomized traffic checked against an arithmetic reference model.
module tb_blc;

    localparam int DW = 16;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int HW = 11;
    localparam int VW = 10;
    localparam int GW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          blc_en;
    logic          cfg_update;
    logic [1:0]    bayer_pattern;
    logic [DW-1:0] blc_r, blc_gr, blc_gb, blc_b;
    logic [GW-1:0] norm_gain;
    logic [DW-1:0] pixel_data_in;
    logic          pixel_data_in_vld;
    logic [DW-1:0] pixel_data_out;
    logic          pixel_data_out_vld;
    logic          blc_done;

    always #5 clk = ~clk;

    blc #(.DW(DW), .H(H), .V(V), .HW(HW), .VW(VW), .GW(GW)) dut (
        .clk                (clk),
        .rst                (rst),
        .blc_en             (blc_en),
        .cfg_update         (cfg_update),
        .bayer_pattern      (bayer_pattern),
        .blc_r              (blc_r),
        .blc_gr             (blc_gr),
        .blc_gb             (blc_gb),
        .blc_b              (blc_b),
        .norm_gain          (norm_gain),
        .pixel_data_in      (pixel_data_in),
        .pixel_data_in_vld  (pixel_data_in_vld),
        .pixel_data_out     (pixel_data_out),
        .pixel_data_out_vld (pixel_data_out_vld),
        .blc_done           (blc_done)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // [pattern][row parity*2 + col parity] -> 0=R 1=Gr 2=Gb 3=B
    int chan_map[4][4] = '{'{0, 1, 2, 3}, '{1, 0, 3, 2}, '{2, 3, 0, 1}, '{3, 2, 1, 0}};

    int row, col;
    int act_off[4];
    int act_gain, act_pat;
    bit act_en, pend;
    bit p_vld, p_done;
    int p_data, hold_data;
    int out_cnt;

    task automatic reset_model();
        row = 0; col = 0;
        act_off = '{0, 0, 0, 0};
        act_gain = 256; act_pat = 0; act_en = 1'b0; pend = 1'b1;
        p_vld = 1'b0; p_done = 1'b0; p_data = 0; hold_data = 0;
        out_cnt = 0;
    endtask

    // One clock: model the beat being offered, then check the output, which
    // reflects the beat offered on the previous call.
    task automatic step(input bit v, input int pix);
        bit c_vld, c_done;
        int c_data, off, d;
        pixel_data_in     = DW'(pix);
        pixel_data_in_vld = v;
        c_vld = v; c_done = 1'b0; c_data = 0;
        if (v) begin
            if (row == 0 && col == 0) begin
                if (pend || cfg_update) begin
                    act_off  = '{int'(blc_r), int'(blc_gr), int'(blc_gb), int'(blc_b)};
                    act_gain = int'(norm_gain);
                    act_pat  = int'(bayer_pattern);
                    act_en   = blc_en;
                    pend     = 1'b0;
                end
            end else if (cfg_update) begin
                pend = 1'b1;
            end
            off = act_off[chan_map[act_pat][(row % 2) * 2 + (col % 2)]];
            if (act_en) begin
                d = (pix > off) ? pix - off : 0;
                d = (d * act_gain + 128) / 256;
                if (d > 65535) d = 65535;
            end else begin
                d = pix;
            end
            c_data = d;
            c_done = (row == V - 1) && (col == H - 1);
            col++;
            if (col == H) begin
                col = 0;
                row++;
                if (row == V) row = 0;
            end
        end else if (cfg_update) begin
            pend = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        cfg_update = 1'b0;
        if (p_vld) hold_data = p_data;
        check("out_vld", pixel_data_out_vld, p_vld);
        check("out_data", pixel_data_out, hold_data);
        check("done", blc_done, p_done);
        if (pixel_data_out_vld) out_cnt++;
        if (blc_done) begin
            check("frame_valid_count", out_cnt, 32);
            out_cnt = 0;
        end
        p_vld = c_vld; p_data = c_data; p_done = c_done;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pixel_data_in_vld = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cfg_update = 1'b0;
        check("rst_vld", pixel_data_out_vld, 0);
        check("rst_data", pixel_data_out, 0);
        check("rst_done", blc_done, 0);
        reset_model();
    endtask

    task automatic run_until(input int r, input int c, input int pix, input bit gaps);
        int n = 0;
        while (!(row == r && col == c) && n < 500) begin
            step(gaps ? ($urandom_range(0, 3) != 0) : 1'b1,
                 (pix < 0) ? int'($urandom_range(0, 65535)) : pix);
            n++;
        end
        if (n >= 500) check("run_until_bound", n, 0);
    endtask

    task automatic set_cfg(input int pat, input int r, input int gr, input int gb,
                           input int b, input int gain, input bit en);
        bayer_pattern = 2'(pat);
        blc_r = DW'(r); blc_gr = DW'(gr); blc_gb = DW'(gb); blc_b = DW'(b);
        norm_gain = GW'(gain); blc_en = en;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cfg_update = 1'b0;
        pixel_data_in = '0; pixel_data_in_vld = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 256, 1'b0);
        do_reset();
        step(1'b0, 0);
        check("idle_after_reset", pixel_data_out_vld, 0);

        // Basic subtraction; first frame loads because of the reset-time pending flag.
        set_cfg(0, 64, 64, 64, 64, 256, 1'b1);
        step(1'b1, 100);
        step(1'b1, 50);
        check("basic_100", pixel_data_out, 36);
        step(1'b0, 0);
        check("basic_50", pixel_data_out, 0);

        // Gain with rounding, armed mid-frame and applied next frame.
        set_cfg(0, 256, 256, 256, 256, 272, 1'b1);
        cfg_update = 1'b1;
        step(1'b1, 7000);
        run_until(0, 0, -1, 1'b1);
        step(1'b1, 4095);
        step(1'b0, 0);
        check("gain_round", pixel_data_out, 4079);
        run_until(0, 0, -1, 1'b1);

        // Saturation with cfg_update coincident with the frame-start beat.
        set_cfg(0, 0, 0, 0, 0, 4095, 1'b1);
        cfg_update = 1'b1;
        step(1'b1, 65535);
        step(1'b0, 0);
        check("saturate", pixel_data_out, 65535);
        run_until(0, 0, -1, 1'b1);

        // Bayer mapping for GRBG.
        set_cfg(1, 10, 20, 30, 40, 256, 1'b1);
        cfg_update = 1'b1;
        step(1'b1, 1000);
        step(1'b1, 1000);
        check("grbg_r0c0", pixel_data_out, 980);
        step(1'b1, 1000);
        check("grbg_r0c1", pixel_data_out, 990);
        run_until(1, 0, 1000, 1'b0);
        step(1'b1, 1000);
        step(1'b1, 1000);
        check("grbg_r1c0", pixel_data_out, 960);
        step(1'b1, 1000);
        check("grbg_r1c1", pixel_data_out, 970);
        run_until(0, 0, 1000, 1'b1);

        // Shadowing: mid-frame R offset change must wait for the next frame.
        set_cfg(0, 10, 10, 10, 10, 256, 1'b1);
        cfg_update = 1'b1;
        run_until(2, 3, 1000, 1'b1);
        blc_r = DW'(50);
        cfg_update = 1'b1;
        step(1'b1, 1000);
        step(1'b1, 1000);
        step(1'b0, 0);
        check("shadow_old_r", pixel_data_out, 990);
        run_until(0, 0, 1000, 1'b1);
        step(1'b1, 1000);
        step(1'b0, 0);
        check("shadow_new_r", pixel_data_out, 950);
        run_until(0, 0, -1, 1'b1);

        // Bypass frame.
        set_cfg(2, 500, 500, 500, 500, 1000, 1'b0);
        cfg_update = 1'b1;
        step(1'b1, 12345);
        step(1'b0, 0);
        check("bypass", pixel_data_out, 12345);
        run_until(0, 0, -1, 1'b1);

        // Randomized traffic with random configuration updates.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)),
                        int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                        int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                        $urandom_range(0, 3) != 0);
                cfg_update = 1'b1;
            end
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 65535)));
        end

        // Reset mid-frame at pixel (1,5), then a full frame counted from (0,0).
        run_until(0, 0, -1, 1'b1);
        run_until(1, 5, -1, 1'b1);
        do_reset();
        set_cfg(3, 100, 200, 300, 400, 300, 1'b1);
        step(1'b1, 20000);
        check("post_rst_flush", pixel_data_out_vld, 0);
        run_until(0, 0, -1, 1'b1);
        step(1'b1, 3000);
        run_until(0, 0, -1, 1'b0);
        step(1'b0, 0);
        step(1'b0, 0);
        step(1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
